hazard_fwd_unit: RTL and testbench

- Decode-stage hazard and forwarding controller that drives the bypass enables and the load-use stall consumed by the decode register read/bypass logic.
- Keeps its own shadow of the destination register, write-enable and load flag for each instruction in EX, MEM and WB.
- Compares those entries against the decode source registers every cycle.
- Also counts stall and flush cycles for performance reporting.

---
 rtl/hazard_fwd_unit_pkg.sv | 24 ++
 rtl/hazard_fwd_unit_match.sv | 19 +
 rtl/hazard_fwd_unit.sv | 114 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the decode-stage hazard/forwarding controller:
// bypass bit positions, slot field layout and forwarding source order.
package hazard_fwd_unit_pkg;

    localparam int BP_RA       = 1;
    localparam int BP_RB       = 0;
    localparam int NUM_OPS     = 2;
    localparam int NUM_SLOTS   = 3;
    localparam int SLOT_CTRL_W = 3;

    // Forwarding priority, youngest first.
    typedef enum logic [1:0] {
        SLOT_EX  = 2'd0,
        SLOT_MEM = 2'd1,
        SLOT_WB  = 2'd2
    } slot_e;

    typedef struct packed {
        logic vld;
        logic we;
        logic ld;
    } slot_ctrl_t;

endpackage

// File: rtl/hazard_fwd_unit_match.sv
// One source-index versus one tracked slot comparator; x0 never matches.
module hazard_match
    import hazard_fwd_unit_pkg::*;
#(
    parameter int ADDR_SIZE = 5
) (
    input  logic [ADDR_SIZE-1:0] src,
    input  logic                 use_src,
    input  logic                 slot_vld,
    input  logic                 slot_we,
    input  logic [ADDR_SIZE-1:0] slot_rd,
    output logic                 match
);

    always_comb begin
        match = use_src && (src != '0) && slot_vld && slot_we && (slot_rd == src);
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard and forwarding controller: shadows EX/MEM/WB destinations,
// picks the youngest bypass source per operand and raises the load-use stall.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 EX_flush,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 D_stall,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    slot_ctrl_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [ADDR_SIZE-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [NUM_OPS-1:0][ADDR_SIZE-1:0] src;
    logic [NUM_OPS-1:0]                use_src;
    logic [NUM_OPS-1:0]                m_ex, m_mem, m_wb;
    logic                              load_use;
    logic                              stall;

    assign src[BP_RA]     = D_ra;
    assign src[BP_RB]     = D_rb;
    assign use_src[BP_RA] = D_valid && D_use_ra;
    assign use_src[BP_RB] = D_valid && D_use_rb;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        hazard_match #(.ADDR_SIZE(ADDR_SIZE)) u_ex (
            .src(src[g]), .use_src(use_src[g]), .slot_vld(ex_q.vld),
            .slot_we(ex_q.we), .slot_rd(ex_rd_q), .match(m_ex[g]));
        hazard_match #(.ADDR_SIZE(ADDR_SIZE)) u_mem (
            .src(src[g]), .use_src(use_src[g]), .slot_vld(mem_q.vld),
            .slot_we(mem_q.we), .slot_rd(mem_rd_q), .match(m_mem[g]));
        hazard_match #(.ADDR_SIZE(ADDR_SIZE)) u_wb (
            .src(src[g]), .use_src(use_src[g]), .slot_vld(wb_q.vld),
            .slot_we(wb_q.we), .slot_rd(wb_rd_q), .match(m_wb[g]));
    end

    // An EX match shadows older slots even when it is a load: the operand
    // must wait for the load data, so no stale MEM/WB value is offered.
    always_comb begin
        EX_D_bp  = '0;
        MEM_D_bp = '0;
        WB_D_bp  = '0;
        for (int op = 0; op < NUM_OPS; op++) begin
            EX_D_bp[op]  = m_ex[op] && !ex_q.ld;
            MEM_D_bp[op] = !m_ex[op] && m_mem[op];
            WB_D_bp[op]  = !m_ex[op] && !m_mem[op] && m_wb[op];
        end
        load_use = (|m_ex) && ex_q.ld;
        stall    = load_use && !EX_flush;
    end

    // Decode hands its instruction to EX on an edge where D_valid=1 and
    // D_stall=0; a flush or stall turns that edge into a bubble instead.
    always_comb begin
        ex_d.vld = D_valid && !stall && !EX_flush;
        ex_d.we  = D_we;
        ex_d.ld  = D_ld;
        ex_rd_d  = D_rd;
        mem_d    = ex_q;
        mem_rd_d = ex_rd_q;
        wb_d     = mem_q;
        wb_rd_d  = mem_rd_q;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (EX_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            ex_rd_q     <= ex_rd_d;
            mem_rd_q    <= mem_rd_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign D_stall   = stall;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with a queue-based scoreboard.
module tb_hazard_fwd_unit;

    localparam int AW = 5;
    localparam int CW = 8;
    localparam int W  = 7 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          D_valid, D_use_ra, D_use_rb, D_we, D_ld, EX_flush;
    logic [AW-1:0] D_ra, D_rb, D_rd;
    logic [1:0]    EX_D_bp, MEM_D_bp, WB_D_bp;
    logic          D_stall;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic [W-1:0]  exp_q[$];
    string         name_q[$];
    logic [CW-1:0] sc, fc;
    int            checks = 0;
    int            errors = 0;

    hazard_fwd_unit #(.ADDR_SIZE(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .D_valid(D_valid), .D_ra(D_ra), .D_rb(D_rb),
        .D_use_ra(D_use_ra), .D_use_rb(D_use_rb), .D_rd(D_rd), .D_we(D_we),
        .D_ld(D_ld), .EX_flush(EX_flush), .EX_D_bp(EX_D_bp), .MEM_D_bp(MEM_D_bp),
        .WB_D_bp(WB_D_bp), .D_stall(D_stall), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt));

    always #5 clk = ~clk;

    // Drive one decode cycle; when chk is set, queue the expected outputs.
    // sc/fc model the counters as seen during this cycle, then advance.
    task automatic step(input string nm, input logic v, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic ura, input logic urb,
                        input logic [AW-1:0] rd, input logic we, input logic ld,
                        input logic fl, input logic [1:0] eex, input logic [1:0] emem,
                        input logic [1:0] ewb, input logic est, input logic chk);
        @(posedge clk);
        #1;
        D_valid = v; D_ra = ra; D_rb = rb; D_use_ra = ura; D_use_rb = urb;
        D_rd = rd; D_we = we; D_ld = ld; EX_flush = fl;
        if (chk) begin
            exp_q.push_back({eex, emem, ewb, est, sc, fc});
            name_q.push_back(nm);
        end
        if (est && sc != '1) sc = sc + 1'b1;
        if (fl && fc != '1) fc = fc + 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    endtask

    // Reset takes effect on the edge that closes the current cycle.
    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sc = '0;
        fc = '0;
    endtask

    initial begin : monitor
        logic [W-1:0] e, a;
        string        nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, stall_cnt, flush_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s actual ex=%b mem=%b wb=%b stall=%b sc=%0d fc=%0d required ex=%b mem=%b wb=%b stall=%b sc=%0d fc=%0d",
                             nm, a[W-1 -: 2], a[W-3 -: 2], a[W-5 -: 2], a[2*CW], a[2*CW-1 -: CW], a[CW-1:0],
                             e[W-1 -: 2], e[W-3 -: 2], e[W-5 -: 2], e[2*CW], e[2*CW-1 -: CW], e[CW-1:0]);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        D_valid = 0; D_ra = 0; D_rb = 0; D_use_ra = 0; D_use_rb = 0;
        D_rd = 0; D_we = 0; D_ld = 0; EX_flush = 0;
        sc = '0; fc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        step("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

        // ALU RAW chain
        step("raw_writer", 1, 0, 0, 0, 0, 3, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        step("raw_ex_fwd", 1, 3, 4, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 1);
        idle(3);

        // Distance ladder: writer r5, unrelated r10, then readers
        step("lad_w5", 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("lad_w10", 1, 0, 0, 0, 0, 10, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("lad_mem", 1, 5, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 1);
        step("lad_wb", 1, 5, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 1);
        step("pri_w5a", 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("pri_w10", 1, 0, 0, 0, 0, 10, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("pri_w5b", 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("pri_ex_wins", 1, 5, 5, 1, 1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
        idle(3);

        // Load-use: ld r7 then store using rb=7
        step("lu_load", 1, 0, 0, 0, 0, 7, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        step("lu_stall", 1, 0, 7, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1);
        step("lu_mem_fwd", 1, 0, 7, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 1);
        idle(3);

        // x0 is never a source; unused operands never forward
        step("x0_load", 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("x0_reader", 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        step("nouse_w9", 1, 0, 0, 0, 0, 9, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("nouse_reader", 1, 9, 9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        step("invalid_reader", 0, 9, 9, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        idle(3);

        // Flush beats stall
        step("fl_load", 1, 0, 0, 0, 0, 2, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("fl_masks_stall", 1, 2, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 1);
        step("fl_after", 1, 2, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 1);
        idle(3);

        // Reset while a stall is pending on r6
        step("rs_w6", 1, 0, 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("rs_ld6", 1, 0, 0, 0, 0, 6, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step("rs_pending", 1, 6, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1);
        pulse_reset();
        step("rs_cleared", 1, 6, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        idle(3);

        // Self-dependent load alternates stall/accept; saturate stall_cnt
        step("sat_first", 1, 1, 0, 1, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step("sat_stall", 1, 1, 0, 1, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1);
            step("sat_accept", 1, 1, 0, 1, 0, 1, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 1);
        end
        idle(3);

        // Saturate flush_cnt
        for (int i = 0; i < (1 << CW) + 3; i++)
            step("sat_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
        step("sat_final", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
